vx_dispatch_mq: RTL and testbench

Parametrised successor to the per-unit dispatch stage: it routes one operand-collected instruction per cycle to one of NUM_EX_UNITS execution-unit queues, each DEPTH entries deep. It computes the first and last active thread IDs and appends them to the payload. It adds behaviour the previous dispatch stage lacked: drop handling for empty-mask and illegal-unit instructions, a global flush, occupancy reporting, and saturating per-unit stall counters. It sits between the operand collector and the execution-unit dispatch interfaces.

---
 rtl/vx_dispatch_mq.sv | 177 +++++++++++++++++
 tb/tb_vx_dispatch_mq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dispatch_mq.sv
// Dispatch stage: routes one instruction per cycle into per-unit FIFOs, tags each
// entry with first/last active thread id, drops empty-mask or illegal-unit work.
module vx_dispatch_mq #(
    parameter int NUM_EX_UNITS = 4,
    parameter int DEPTH        = 2,
    parameter int DATAW        = 128,
    parameter int NUM_THREADS  = 4,
    parameter int EX_BITS      = 2,
    parameter int CTR_BITS     = 16,
    localparam int TIDW        = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int OCCW        = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [EX_BITS-1:0]                   in_ex_type,
    input  logic [NUM_THREADS-1:0]               in_tmask,
    input  logic [DATAW-1:0]                     in_data,
    output logic [NUM_EX_UNITS-1:0]              out_valid,
    input  logic [NUM_EX_UNITS-1:0]              out_ready,
    output logic [NUM_EX_UNITS*DATAW-1:0]        out_data,
    output logic [NUM_EX_UNITS*NUM_THREADS-1:0]  out_tmask,
    output logic [NUM_EX_UNITS*TIDW-1:0]         out_first_tid,
    output logic [NUM_EX_UNITS*TIDW-1:0]         out_last_tid,
    output logic [NUM_EX_UNITS*OCCW-1:0]         occupancy,
    output logic [NUM_EX_UNITS*CTR_BITS-1:0]     stall_cnt,
    output logic [CTR_BITS-1:0]                  drop_cnt,
    output logic                                 err_ex_type
);
    localparam int PTRW = $clog2(DEPTH);
    typedef logic [PTRW-1:0] ptr_t;

    logic [DATAW-1:0]       data_q  [NUM_EX_UNITS][DEPTH];
    logic [DATAW-1:0]       data_d  [NUM_EX_UNITS][DEPTH];
    logic [NUM_THREADS-1:0] tmask_q [NUM_EX_UNITS][DEPTH];
    logic [NUM_THREADS-1:0] tmask_d [NUM_EX_UNITS][DEPTH];
    logic [TIDW-1:0]        ftid_q  [NUM_EX_UNITS][DEPTH];
    logic [TIDW-1:0]        ftid_d  [NUM_EX_UNITS][DEPTH];
    logic [TIDW-1:0]        ltid_q  [NUM_EX_UNITS][DEPTH];
    logic [TIDW-1:0]        ltid_d  [NUM_EX_UNITS][DEPTH];
    ptr_t                   rd_q    [NUM_EX_UNITS];
    ptr_t                   rd_d    [NUM_EX_UNITS];
    ptr_t                   wr_q    [NUM_EX_UNITS];
    ptr_t                   wr_d    [NUM_EX_UNITS];
    logic [OCCW-1:0]        occ_q   [NUM_EX_UNITS];
    logic [OCCW-1:0]        occ_d   [NUM_EX_UNITS];
    logic [CTR_BITS-1:0]    stall_q [NUM_EX_UNITS];
    logic [CTR_BITS-1:0]    stall_d [NUM_EX_UNITS];
    logic [CTR_BITS-1:0]    drop_q, drop_d;
    logic                   err_q, err_d;

    logic [TIDW-1:0]        first_tid, last_tid;
    logic                   unit_legal, unit_full, drop_sel, fire;
    logic [NUM_EX_UNITS-1:0] push, pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    // in_ready sees only registered occupancy and input fields, never out_ready
    always_comb begin
        first_tid  = '0;
        last_tid   = '0;
        unit_legal = 1'b0;
        unit_full  = 1'b0;
        for (int unsigned t = 0; t < NUM_THREADS; t++)
            if (in_tmask[t]) last_tid = TIDW'(t);
        for (int unsigned t = NUM_THREADS; t > 0; t--)
            if (in_tmask[t-1]) first_tid = TIDW'(t - 1);
        for (int unsigned i = 0; i < NUM_EX_UNITS; i++) begin
            if (in_ex_type == EX_BITS'(i)) begin
                unit_legal = 1'b1;
                unit_full  = (occ_q[i] == OCCW'(DEPTH));
            end
        end
        drop_sel = ~unit_legal | (in_tmask == '0);
        in_ready = reset & (drop_sel | (~unit_full & ~flush));
        fire     = in_valid & in_ready;
    end

    always_comb begin
        data_d  = data_q;
        tmask_d = tmask_q;
        ftid_d  = ftid_q;
        ltid_d  = ltid_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        occ_d   = occ_q;
        stall_d = stall_q;
        drop_d  = drop_q;
        err_d   = err_q;
        push    = '0;
        pop     = '0;
        if (fire && drop_sel) begin
            if (drop_q != '1) drop_d = drop_q + CTR_BITS'(1);
            if (!unit_legal) err_d = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_EX_UNITS; i++) begin
            push[i] = fire & ~drop_sel & (in_ex_type == EX_BITS'(i));
            pop[i]  = (occ_q[i] != '0) & out_ready[i];
            if (in_valid && !in_ready && (in_ex_type == EX_BITS'(i)) && (stall_q[i] != '1))
                stall_d[i] = stall_q[i] + CTR_BITS'(1);
            if (push[i]) begin
                data_d[i][wr_q[i]]  = in_data;
                tmask_d[i][wr_q[i]] = in_tmask;
                ftid_d[i][wr_q[i]]  = first_tid;
                ltid_d[i][wr_q[i]]  = last_tid;
                wr_d[i]             = ptr_inc(wr_q[i]);
            end
            if (pop[i]) rd_d[i] = ptr_inc(rd_q[i]);
            case ({push[i], pop[i]})
                2'b10:   occ_d[i] = occ_q[i] + OCCW'(1);
                2'b01:   occ_d[i] = occ_q[i] - OCCW'(1);
                default: occ_d[i] = occ_q[i];
            endcase
            if (flush) begin
                rd_d[i]  = '0;
                wr_d[i]  = '0;
                occ_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_EX_UNITS; i++) begin
                rd_q[i]    <= '0;
                wr_q[i]    <= '0;
                occ_q[i]   <= '0;
                stall_q[i] <= '0;
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    data_q[i][j]  <= '0;
                    tmask_q[i][j] <= '0;
                    ftid_q[i][j]  <= '0;
                    ltid_q[i][j]  <= '0;
                end
            end
            drop_q <= '0;
            err_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            tmask_q <= tmask_d;
            ftid_q  <= ftid_d;
            ltid_q  <= ltid_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        out_valid     = '0;
        out_data      = '0;
        out_tmask     = '0;
        out_first_tid = '0;
        out_last_tid  = '0;
        occupancy     = '0;
        stall_cnt     = '0;
        for (int unsigned i = 0; i < NUM_EX_UNITS; i++) begin
            out_valid[i]                              = (occ_q[i] != '0);
            out_data[i*DATAW +: DATAW]                = data_q[i][rd_q[i]];
            out_tmask[i*NUM_THREADS +: NUM_THREADS]   = tmask_q[i][rd_q[i]];
            out_first_tid[i*TIDW +: TIDW]             = ftid_q[i][rd_q[i]];
            out_last_tid[i*TIDW +: TIDW]              = ltid_q[i][rd_q[i]];
            occupancy[i*OCCW +: OCCW]                 = occ_q[i];
            stall_cnt[i*CTR_BITS +: CTR_BITS]         = stall_q[i];
        end
    end

    assign drop_cnt    = drop_q;
    assign err_ex_type = err_q;
endmodule

// File: tb/tb_vx_dispatch_mq.sv
// Scoreboard bench for vx_dispatch_mq: stimulus pushes expected entries per unit,
// a negedge monitor pops and compares whenever a unit hands off an entry.
module tb_vx_dispatch_mq;
    localparam int NU = 3;
    localparam int DP = 3;
    localparam int DW = 16;
    localparam int NT = 4;
    localparam int EB = 2;
    localparam int CB = 4;
    localparam int TW = 2;
    localparam int OW = 2;
    localparam int EW = DW + NT + 2 * TW;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [EB-1:0]    in_ex_type = '0;
    logic [NT-1:0]    in_tmask = '0;
    logic [DW-1:0]    in_data = '0;
    logic [NU-1:0]    out_valid;
    logic [NU-1:0]    out_ready = '0;
    logic [NU*DW-1:0] out_data;
    logic [NU*NT-1:0] out_tmask;
    logic [NU*TW-1:0] out_first_tid;
    logic [NU*TW-1:0] out_last_tid;
    logic [NU*OW-1:0] occupancy;
    logic [NU*CB-1:0] stall_cnt;
    logic [CB-1:0]    drop_cnt;
    logic             err_ex_type;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] sb [NU][$];

    // hand-computed thread-mask vectors with their first/last active tid
    logic [NT-1:0] tm_tab [8] = '{4'b0110, 4'b0001, 4'b1000, 4'b1111, 4'b1010, 4'b0101, 4'b1001, 4'b0100};
    logic [TW-1:0] ft_tab [8] = '{2'd1, 2'd0, 2'd3, 2'd0, 2'd1, 2'd0, 2'd0, 2'd2};
    logic [TW-1:0] lt_tab [8] = '{2'd2, 2'd0, 2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd2};

    vx_dispatch_mq #(
        .NUM_EX_UNITS(NU), .DEPTH(DP), .DATAW(DW),
        .NUM_THREADS(NT), .EX_BITS(EB), .CTR_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ex_type(in_ex_type),
        .in_tmask(in_tmask), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tmask(out_tmask), .out_first_tid(out_first_tid), .out_last_tid(out_last_tid),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt),
        .err_ex_type(err_ex_type)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] occ(input int u);
        return occupancy[u*OW +: OW];
    endfunction

    function automatic logic [CB-1:0] stl(input int u);
        return stall_cnt[u*CB +: CB];
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < NU; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    if (sb[i].size() == 0) begin
                        chk($sformatf("unexpected_out_u%0d", i), {8'h0, out_data[i*DW +: DW], 8'h0}, 32'hffffffff);
                    end else begin
                        chk($sformatf("head_u%0d", i),
                            {8'h0, out_data[i*DW +: DW], out_tmask[i*NT +: NT],
                             out_first_tid[i*TW +: TW], out_last_tid[i*TW +: TW]},
                            {8'h0, sb[i].pop_front()});
                    end
                end
            end
        end
    end

    // drive one instruction for one cycle; acc is the hand-derived in_ready
    task automatic put(input logic [EB-1:0] ex, input logic [NT-1:0] tm, input logic [DW-1:0] d,
                       input logic [TW-1:0] f, input logic [TW-1:0] l, input logic acc, input string nm);
        in_valid = 1'b1; in_ex_type = ex; in_tmask = tm; in_data = d;
        #1;
        chk(nm, {31'h0, in_ready}, {31'h0, acc});
        if (acc && ex < EB'(NU) && tm != '0) sb[ex].push_back({d, tm, f, l});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic stall_hold(input int n);
        in_valid = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_out_valid", {29'h0, out_valid}, 32'h0);
        chk("rst_occupancy", {26'h0, occupancy}, 32'h0);
        chk("rst_counters", {15'h0, stall_cnt, drop_cnt, err_ex_type}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        idle(1);

        // fill unit 1, then a fourth instruction stalls
        put(2'd1, 4'b0110, 16'hA001, 2'd1, 2'd2, 1'b1, "t1_acc0");
        put(2'd1, 4'b0110, 16'hA002, 2'd1, 2'd2, 1'b1, "t1_acc1");
        put(2'd1, 4'b0110, 16'hA003, 2'd1, 2'd2, 1'b1, "t1_acc2");
        chk("t1_occ_full", {30'h0, occ(1)}, 32'd3);
        put(2'd1, 4'b0110, 16'hA004, 2'd1, 2'd2, 1'b0, "t1_stall_ready");
        stall_hold(1);
        chk("t1_stall_cnt", {28'h0, stl(1)}, 32'd2);
        chk("t1_out_valid", {29'h0, out_valid}, 32'b010);
        chk("t1_first_tid", {30'h0, out_first_tid[1*TW +: TW]}, 32'd1);
        chk("t1_last_tid", {30'h0, out_last_tid[1*TW +: TW]}, 32'd2);

        // one pop while full: push still refused in that same cycle
        out_ready[1] = 1'b1;
        stall_hold(1);
        out_ready[1] = 1'b0;
        chk("t2_occ_after_pop", {30'h0, occ(1)}, 32'd2);
        chk("t2_stall_cnt", {28'h0, stl(1)}, 32'd3);
        put(2'd1, 4'b0110, 16'hA004, 2'd1, 2'd2, 1'b1, "t2_retry");
        chk("t2_occ_refill", {30'h0, occ(1)}, 32'd3);
        out_ready[1] = 1'b1;
        idle(3);
        out_ready[1] = 1'b0;
        chk("t2_drained", {29'h0, out_valid}, 32'h0);

        // drops: empty mask, then illegal unit
        put(2'd0, 4'b0000, 16'hBBB0, 2'd0, 2'd0, 1'b1, "t3_empty_ready");
        chk("t3_drop1", {28'h0, drop_cnt}, 32'd1);
        chk("t3_err1", {31'h0, err_ex_type}, 32'h0);
        put(2'd3, 4'b0110, 16'hBBB1, 2'd1, 2'd2, 1'b1, "t3_illegal_ready");
        chk("t3_drop2", {28'h0, drop_cnt}, 32'd2);
        chk("t3_err2", {31'h0, err_ex_type}, 32'h1);
        chk("t3_no_valid", {29'h0, out_valid}, 32'h0);

        // streaming through unit 2 wraps the pointers several times
        out_ready[2] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            put(2'd2, tm_tab[k % 8], 16'hC000 + 16'(k), ft_tab[k % 8], lt_tab[k % 8], 1'b1, "t4_ready");
            chk("t4_occ", {30'h0, occ(2)}, 32'd1);
        end
        idle(1);
        out_ready[2] = 1'b0;
        chk("t4_occ_empty", {30'h0, occ(2)}, 32'd0);
        for (int i = 0; i < NU; i++) chk($sformatf("t4_sb_empty_u%0d", i), sb[i].size(), 32'd0);

        // fill units 0 and 2, saturate stall counter of unit 0, then flush
        put(2'd0, tm_tab[1], 16'hD000, ft_tab[1], lt_tab[1], 1'b1, "t5_u0_a");
        put(2'd0, tm_tab[3], 16'hD001, ft_tab[3], lt_tab[3], 1'b1, "t5_u0_b");
        put(2'd0, tm_tab[4], 16'hD002, ft_tab[4], lt_tab[4], 1'b1, "t5_u0_c");
        put(2'd2, tm_tab[7], 16'hE000, ft_tab[7], lt_tab[7], 1'b1, "t5_u2_a");
        put(2'd2, tm_tab[2], 16'hE001, ft_tab[2], lt_tab[2], 1'b1, "t5_u2_b");
        chk("t5_occ", {26'h0, occupancy}, {26'h0, 2'd2, 2'd0, 2'd3});
        put(2'd0, tm_tab[0], 16'hD003, ft_tab[0], lt_tab[0], 1'b0, "t5_full_ready");
        stall_hold(19);
        chk("t5_stall_sat", {28'h0, stl(0)}, 32'd15);
        in_valid = 1'b1;
        flush = 1'b1;
        #1;
        chk("t5_flush_ready", {31'h0, in_ready}, 32'h0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush = 1'b0;
        sb[0].delete();
        sb[2].delete();
        chk("t5_occ_zero", {26'h0, occupancy}, 32'h0);
        chk("t5_valid_zero", {29'h0, out_valid}, 32'h0);
        chk("t5_stall_kept", {20'h0, stall_cnt}, {20'h0, 4'd0, 4'd3, 4'd15});
        flush = 1'b1;
        put(2'd1, 4'b0000, 16'hF000, 2'd0, 2'd0, 1'b1, "t5_drop_in_flush");
        flush = 1'b0;
        chk("t5_drop3", {28'h0, drop_cnt}, 32'd3);
        chk("t5_err_kept", {31'h0, err_ex_type}, 32'h1);
        put(2'd0, 4'b0000, 16'hF001, 2'd0, 2'd0, 1'b1, "t5_drop_more");
        stall_hold(13);
        chk("t5_drop_sat", {28'h0, drop_cnt}, 32'd15);

        // async reset between edges with entries queued
        put(2'd1, tm_tab[0], 16'hF100, ft_tab[0], lt_tab[0], 1'b1, "t6_acc0");
        put(2'd1, tm_tab[1], 16'hF101, ft_tab[1], lt_tab[1], 1'b1, "t6_acc1");
        chk("t6_pre_valid", {29'h0, out_valid}, 32'b010);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", {29'h0, out_valid}, 32'h0);
        chk("t6_occ", {26'h0, occupancy}, 32'h0);
        chk("t6_counters", {15'h0, stall_cnt, drop_cnt, err_ex_type}, 32'h0);
        chk("t6_in_ready", {31'h0, in_ready}, 32'h0);
        sb[1].delete();
        in_valid = 1'b1; in_ex_type = 2'd1; in_tmask = 4'b0110;
        @(posedge clk); #1;
        chk("t6_ready_held", {31'h0, in_ready}, 32'h0);
        chk("t6_occ_held", {26'h0, occupancy}, 32'h0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_ready_back", {31'h0, in_ready}, 32'h1);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
